// File: rtl/seq_alu_if.sv
// Start/done handshake bundle between a requester and the sequential ALU.
// The requester drives the operation; the ALU returns result and status flags.
interface seq_alu_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = 5
);
    logic             start;
    logic [3:0]       alucontrol;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [SHW-1:0]   shamt;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             illegal;

    modport master (
        output start, alucontrol, a, b, shamt,
        input  ready, done, result, zero, illegal
    );

    modport slave (
        input  start, alucontrol, a, b, shamt,
        output ready, done, result, zero, illegal
    );
endinterface

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arithmetic ops, iterative 1-bit-per-cycle sll,
// results returned through a start/done handshake.
module seq_alu #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = 5
) (
    input  logic        clk,
    input  logic        reset,
    seq_alu_if.slave    bus
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_SGT = 4'b1111;
    localparam logic [3:0] OP_SLL = 4'b1000;
    localparam logic [3:0] OP_ZFR = 4'b1001;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             illegal_q, illegal_d;
    logic             ready_q, ready_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] op_res_c;
    logic             op_ill_c;
    logic [WIDTH-1:0] shl1_c;

    // Single-cycle result from the live inputs; only used on the accept edge.
    always_comb begin
        op_res_c = '0;
        op_ill_c = 1'b0;
        unique case (bus.alucontrol)
            OP_ADD:  op_res_c = bus.a + bus.b;
            OP_SUB:  op_res_c = bus.a - bus.b;
            OP_AND:  op_res_c = bus.a & bus.b;
            OP_OR:   op_res_c = bus.a | bus.b;
            OP_SLT:  op_res_c = WIDTH'($signed(bus.a) < $signed(bus.b));
            OP_SGT:  op_res_c = WIDTH'($signed(bus.a) > $signed(bus.b));
            OP_SLL:  op_res_c = bus.b;
            OP_ZFR:  op_res_c = bus.a & ({WIDTH{1'b1}} << bus.b[SHW-1:0]);
            default: op_ill_c = 1'b1;
        endcase
    end

    assign shl1_c = {work_q[WIDTH-2:0], 1'b0};

    // Next-state and output-register logic.
    always_comb begin
        state_d   = state_q;
        work_d    = work_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.alucontrol == OP_SLL && bus.shamt != '0) begin
                        work_d  = bus.b;
                        cnt_d   = bus.shamt;
                        state_d = SHIFT;
                    end else begin
                        result_d  = op_res_c;
                        zero_d    = (op_res_c == '0);
                        illegal_d = op_ill_c;
                        state_d   = DONE;
                    end
                end
            end
            SHIFT: begin
                work_d = shl1_c;
                cnt_d  = cnt_q - SHW'(1);
                if (cnt_q == SHW'(1)) begin
                    result_d  = shl1_c;
                    zero_d    = (shl1_c == '0);
                    illegal_d = 1'b0;
                    state_d   = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == IDLE);
        done_d  = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            work_q    <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
            zero_q    <= 1'b1;
            illegal_q <= 1'b0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            work_q    <= work_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
        end
    end

    assign bus.ready   = ready_q;
    assign bus.done    = done_q;
    assign bus.result  = result_q;
    assign bus.zero    = zero_q;
    assign bus.illegal = illegal_q;

endmodule
